bg_scroll_ctrl: RTL and testbench

Vertical background scroll controller for the PPU background path. It keeps the per-frame scroll offset and a 32-row ring-buffer map in nametable and attribute RAM. It issues one row-load request per 16-pixel scroll step to the downstream flash-to-nametable loader, which streams the bytes from SPI flash. After reset or restart it first preloads one screen plus one row of map data.

---
 rtl/bg_scroll_ctrl_if.sv | 34 +++
 rtl/bg_scroll_ctrl.sv | 129 ++++++++++++
 tb/tb_bg_scroll_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_scroll_ctrl_if.sv
// Row-load request bus between the scroll controller and the flash-to-nametable loader.
// Handshake: a request is a one-cycle strobe on both read flags with the addresses held
// from the strobe until the next one. flashBusy is the loader's not-ready signal. The
// controller only strobes while flashBusy is low, and ignores it briefly after each strobe
// while the loader's busy response is still on its way.
interface bg_scroll_ctrl_if;
  logic [23:0] flashAddrNametable;
  logic [23:0] flashAddrAttribute;
  logic        flashReadNametableFlag;
  logic        flashReadAttributeFlag;
  logic [8:0]  nametableRamAddrStart;
  logic [8:0]  attributeRamAddrStart;
  logic        flashBusy;

  modport master (
    output flashAddrNametable,
    output flashAddrAttribute,
    output flashReadNametableFlag,
    output flashReadAttributeFlag,
    output nametableRamAddrStart,
    output attributeRamAddrStart,
    input  flashBusy
  );

  modport slave (
    input  flashAddrNametable,
    input  flashAddrAttribute,
    input  flashReadNametableFlag,
    input  flashReadAttributeFlag,
    input  nametableRamAddrStart,
    input  attributeRamAddrStart,
    output flashBusy
  );
endinterface

// File: rtl/bg_scroll_ctrl.sv
// Vertical background scroll controller: tracks scrollY in a 512-pixel ring and requests
// one 16-pixel map row from flash per scroll step, after preloading the first screen.
module bg_scroll_ctrl #(
  parameter logic [23:0] NT_BASE      = 24'h550000,
  parameter logic [23:0] AT_BASE      = 24'h551000,
  parameter int          MAP_ROWS     = 256,
  parameter int          PRELOAD_ROWS = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frameTick,
  input  logic              scrollEn,
  input  logic [1:0]        scrollSpeed,
  input  logic              mapRestart,
  bg_scroll_ctrl_if.master  flash,
  output logic [8:0]        scrollY,
  output logic              mapEnd,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    PRE_REQ  = 3'd0,
    PRE_WAIT = 3'd1,
    RUN      = 3'd2,
    RUN_WAIT = 3'd3,
    END      = 3'd4
  } state_t;

  localparam logic [15:0] LAST_ROW  = 16'(MAP_ROWS);
  localparam logic [15:0] PRELOAD_N = 16'(PRELOAD_ROWS);

  state_t      state;
  logic [15:0] next_row;
  logic        pending;
  logic [1:0]  guard;

  logic [8:0]  y_next;
  logic        crossing;
  logic        advance;
  logic        end_hit;
  logic        issue;
  logic        wait_done;

  assign state_dbg = state;

  assign y_next   = scrollY + {7'd0, scrollSpeed};
  assign crossing = (y_next[8:4] != scrollY[8:4]);
  assign advance  = frameTick & scrollEn & ~pending & ~mapRestart &
                    ((state == RUN) || (state == RUN_WAIT));
  // Crossing into a row that does not exist: stop without showing it.
  assign end_hit  = advance & crossing & (next_row == LAST_ROW);

  assign issue = ~mapRestart & ~flash.flashBusy &
                 ((state == PRE_REQ) || ((state == RUN) && pending));

  // Busy is honoured from the edge on which guard expires (loaded 2, counts down), which
  // gives the loader time to raise busy and keeps strobes at least 3 cycles apart.
  assign wait_done = (guard <= 2'd1) & ~flash.flashBusy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                        <= PRE_REQ;
      next_row                     <= '0;
      pending                      <= 1'b0;
      guard                        <= '0;
      scrollY                      <= '0;
      mapEnd                       <= 1'b0;
      flash.flashAddrNametable     <= NT_BASE;
      flash.flashAddrAttribute     <= AT_BASE;
      flash.flashReadNametableFlag <= 1'b0;
      flash.flashReadAttributeFlag <= 1'b0;
      flash.nametableRamAddrStart  <= '0;
      flash.attributeRamAddrStart  <= '0;
    end else begin
      flash.flashReadNametableFlag <= 1'b0;
      flash.flashReadAttributeFlag <= 1'b0;

      if (issue) begin
        flash.flashAddrNametable     <= NT_BASE + {4'd0, next_row, 4'd0};
        flash.flashAddrAttribute     <= AT_BASE + {6'd0, next_row, 2'd0};
        flash.nametableRamAddrStart  <= {next_row[4:0], 4'd0};
        flash.attributeRamAddrStart  <= {2'd0, next_row[4:0], 2'd0};
        flash.flashReadNametableFlag <= 1'b1;
        flash.flashReadAttributeFlag <= 1'b1;
        next_row                     <= next_row + 16'd1;
        guard                        <= 2'd2;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end

      if (mapRestart) begin
        next_row <= '0;
        scrollY  <= '0;
        pending  <= 1'b0;
        mapEnd   <= 1'b0;
        state    <= PRE_REQ;
      end else begin
        case (state)
          PRE_REQ: begin
            if (issue) state <= PRE_WAIT;
          end
          PRE_WAIT: begin
            if (wait_done) state <= (next_row < PRELOAD_N) ? PRE_REQ : RUN;
          end
          RUN, RUN_WAIT: begin
            if (end_hit) begin
              state  <= END;
              mapEnd <= 1'b1;
            end else begin
              if (advance) begin
                scrollY <= y_next;
                if (crossing) pending <= 1'b1;
              end
              if (issue) begin
                pending <= 1'b0;
                state   <= RUN_WAIT;
              end else if ((state == RUN_WAIT) && wait_done) begin
                state <= RUN;
              end
            end
          end
          END:     state <= END;
          default: state <= PRE_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Bench for bg_scroll_ctrl: a 256-row instance for preload, scrolling, busy, wrap and
// restart, plus a 20-row instance for the end-of-map stop.
module tb_bg_scroll_ctrl;

  localparam logic [23:0] NT_BASE = 24'h550000;
  localparam logic [23:0] AT_BASE = 24'h551000;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // main instance
  logic       frame_tick = 1'b0;
  logic       scroll_en  = 1'b0;
  logic [1:0] scroll_speed = 2'd0;
  logic       map_restart = 1'b0;
  logic [8:0] scroll_y;
  logic       map_end;
  logic [2:0] state_dbg;
  bg_scroll_ctrl_if fl ();

  bg_scroll_ctrl #(.MAP_ROWS(256)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frameTick   (frame_tick),
    .scrollEn    (scroll_en),
    .scrollSpeed (scroll_speed),
    .mapRestart  (map_restart),
    .flash       (fl),
    .scrollY     (scroll_y),
    .mapEnd      (map_end),
    .state_dbg   (state_dbg)
  );

  // short-map instance
  logic       s_tick = 1'b0;
  logic       s_en = 1'b1;
  logic [1:0] s_spd = 2'd3;
  logic       s_restart = 1'b0;
  logic [8:0] s_y;
  logic       s_end;
  logic [2:0] s_state;
  bg_scroll_ctrl_if fs ();

  bg_scroll_ctrl #(.MAP_ROWS(20)) dut_s (
    .clk         (clk),
    .rstn        (rstn),
    .frameTick   (s_tick),
    .scrollEn    (s_en),
    .scrollSpeed (s_spd),
    .mapRestart  (s_restart),
    .flash       (fs),
    .scrollY     (s_y),
    .mapEnd      (s_end),
    .state_dbg   (s_state)
  );

  // scoreboard
  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_row = 16'd0;
  logic [8:0]  sy = 9'd0;
  bit          m_pending = 1'b0;
  bit          preload_phase = 1'b0;
  int          strobes = 0;
  int          last_strobe = -1;
  int          s_strobes = 0;
  logic [23:0] s_last_nt = 24'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rstn && (fl.flashReadNametableFlag || fl.flashReadAttributeFlag)) begin
      logic [15:0] row;
      check("nt_flag", {31'd0, fl.flashReadNametableFlag}, 32'd1);
      check("at_flag", {31'd0, fl.flashReadAttributeFlag}, 32'd1);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got NT addr 0x%0h expected no strobe", fl.flashAddrNametable);
      end else begin
        row = exp_q.pop_front();
        check("nt_addr", {8'd0, fl.flashAddrNametable}, {8'd0, NT_BASE + 24'(row) * 24'd16});
        check("at_addr", {8'd0, fl.flashAddrAttribute}, {8'd0, AT_BASE + 24'(row) * 24'd4});
        check("nt_ram", {23'd0, fl.nametableRamAddrStart}, 32'((row % 16'd32) * 16'd16));
        check("at_ram", {23'd0, fl.attributeRamAddrStart}, 32'((row % 16'd32) * 16'd4));
      end
      if (last_strobe >= 0) begin
        if (preload_phase) check("preload_gap", cyc - last_strobe, 32'd3);
        else               check("gap_ge3", {31'd0, (cyc - last_strobe) >= 3}, 32'd1);
      end
      strobes++;
      last_strobe = cyc;
      m_pending   = 1'b0;
    end
    if (rstn && fs.flashReadNametableFlag) begin
      s_strobes++;
      s_last_nt = fs.flashAddrNametable;
    end
  end

  // driver: one frameTick on the main instance, with the scroll model updated alongside
  task automatic tick(input logic en, input logic [1:0] spd);
    logic [8:0] ny;
    scroll_en    = en;
    scroll_speed = spd;
    frame_tick   = 1'b1;
    if (en && !m_pending) begin
      ny = sy + 9'(spd);
      if (ny[8:4] != sy[8:4]) begin
        exp_q.push_back(exp_row);
        exp_row++;
        m_pending = 1'b1;
      end
      sy = ny;
    end
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("model_y", {23'd0, scroll_y}, {23'd0, sy});
  endtask

  task automatic s_frame();
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] spd;
    logic [8:0] exp_y;
    int         exp_strobes;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int s0;
    vecs = '{
      '{1'b1, 2'd3, 9'd3,  0}, '{1'b1, 2'd3, 9'd6,  0}, '{1'b1, 2'd3, 9'd9,  0},
      '{1'b1, 2'd3, 9'd12, 0}, '{1'b1, 2'd3, 9'd15, 0}, '{1'b1, 2'd3, 9'd18, 1},
      '{1'b0, 2'd3, 9'd18, 0}, '{1'b1, 2'd0, 9'd18, 0}, '{1'b1, 2'd1, 9'd19, 0},
      '{1'b1, 2'd2, 9'd21, 0}
    };
    fl.flashBusy = 1'b0;
    fs.flashBusy = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_scroll_y", {23'd0, scroll_y}, 32'd0);
    check("rst_map_end", {31'd0, map_end}, 32'd0);
    check("rst_nt_flag", {31'd0, fl.flashReadNametableFlag}, 32'd0);
    check("rst_at_flag", {31'd0, fl.flashReadAttributeFlag}, 32'd0);
    check("rst_nt_addr", {8'd0, fl.flashAddrNametable}, 32'h550000);
    check("rst_at_addr", {8'd0, fl.flashAddrAttribute}, 32'h551000);
    check("rst_nt_ram", {23'd0, fl.nametableRamAddrStart}, 32'd0);
    check("rst_at_ram", {23'd0, fl.attributeRamAddrStart}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);

    // preload: rows 0..15, one every 3 cycles
    for (int r = 0; r < 16; r++) exp_q.push_back(16'(r));
    exp_row = 16'd16;
    preload_phase = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    check("first_strobe", {31'd0, fl.flashReadNametableFlag}, 32'd1);
    for (int i = 0; i < 100 && state_dbg != 3'd2; i++) @(negedge clk);
    preload_phase = 1'b0;
    check("preload_state_run", {29'd0, state_dbg}, 32'd2);
    check("preload_strobes", strobes, 32'd16);
    check("preload_last_nt", {8'd0, fl.flashAddrNametable}, 32'h5500F0);
    check("preload_last_at_ram", {23'd0, fl.attributeRamAddrStart}, 32'd60);

    // table-driven scroll vectors
    for (int i = 0; i < 10; i++) begin
      s0 = strobes;
      tick(vecs[i].en, vecs[i].spd);
      check($sformatf("vec%0d_y", i), {23'd0, scroll_y}, {23'd0, vecs[i].exp_y});
      check($sformatf("vec%0d_strobes", i), strobes - s0, vecs[i].exp_strobes);
    end
    check("row16_nt_ram", {23'd0, fl.nametableRamAddrStart}, 32'd256);

    // busy held across a crossing: scroll frozen, strobe one cycle after busy drops
    fl.flashBusy = 1'b1;
    s0 = strobes;
    repeat (4) tick(1'b1, 2'd3);
    check("busy_cross_y", {23'd0, scroll_y}, 32'd33);
    repeat (3) tick(1'b1, 2'd3);
    check("busy_frozen_y", {23'd0, scroll_y}, 32'd33);
    check("busy_no_strobe", strobes - s0, 32'd0);
    fl.flashBusy = 1'b0;
    @(negedge clk);
    check("busy_release_strobe", {31'd0, fl.flashReadNametableFlag}, 32'd1);
    repeat (3) @(negedge clk);

    // ring wrap 509 + 3 -> 0 (rows pass through slot 0 at row 32 on the way)
    repeat (158) tick(1'b1, 2'd3);
    tick(1'b1, 2'd2);
    check("wrap_pre_y", {23'd0, scroll_y}, 32'd509);
    tick(1'b1, 2'd3);
    check("wrap_y", {23'd0, scroll_y}, 32'd0);
    check("wrap_nt_ram", {23'd0, fl.nametableRamAddrStart}, 32'd240);
    check("wrap_row_count", {16'd0, exp_row}, 32'd48);
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // restart while in RUN_WAIT with the loader busy
    repeat (5) tick(1'b1, 2'd3);
    scroll_en = 1'b1; scroll_speed = 2'd3; frame_tick = 1'b1;
    exp_q.push_back(exp_row); exp_row++; sy = 9'd18; m_pending = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 8 && !fl.flashReadNametableFlag; k++) @(negedge clk);
    check("restart_pre_strobe", {31'd0, fl.flashReadNametableFlag}, 32'd1);
    @(negedge clk);
    check("restart_in_run_wait", {29'd0, state_dbg}, 32'd3);
    fl.flashBusy = 1'b1; map_restart = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    map_restart = 1'b0; frame_tick = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 16; r++) exp_q.push_back(16'(r));
    exp_row = 16'd16; sy = 9'd0; m_pending = 1'b0;
    last_strobe = -1; preload_phase = 1'b1;
    s0 = strobes;
    repeat (6) @(negedge clk);
    check("restart_no_strobe", strobes - s0, 32'd0);
    check("restart_state", {29'd0, state_dbg}, 32'd0);
    check("restart_y", {23'd0, scroll_y}, 32'd0);
    check("restart_map_end", {31'd0, map_end}, 32'd0);
    fl.flashBusy = 1'b0;
    @(negedge clk);
    check("restart_strobe", {31'd0, fl.flashReadNametableFlag}, 32'd1);
    check("restart_row0_nt", {8'd0, fl.flashAddrNametable}, 32'h550000);
    check("restart_row0_ram", {23'd0, fl.nametableRamAddrStart}, 32'd0);
    for (int i = 0; i < 100 && state_dbg != 3'd2; i++) @(negedge clk);
    preload_phase = 1'b0;
    check("restart_run", {29'd0, state_dbg}, 32'd2);
    check("restart_preload_count", strobes - s0, 32'd16);
    check("restart_queue_empty", exp_q.size(), 32'd0);

    // end of map on the 20-row instance: crossings load rows 16..19, the next one stops
    repeat (26) s_frame();
    check("end_pre_y", {23'd0, s_y}, 32'd78);
    check("end_pre_flag", {31'd0, s_end}, 32'd0);
    check("end_pre_strobes", s_strobes, 32'd20);
    check("end_last_nt", {8'd0, s_last_nt}, 32'h550130);
    s_frame();
    check("end_flag", {31'd0, s_end}, 32'd1);
    check("end_state", {29'd0, s_state}, 32'd4);
    check("end_y", {23'd0, s_y}, 32'd78);
    repeat (3) s_frame();
    check("end_frozen_y", {23'd0, s_y}, 32'd78);
    check("end_no_strobe", s_strobes, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
